// File: rtl/icw_ocw_sequencer_pkg.sv
// Shared definitions for the ICW/OCW command-word sequencer: state encoding
// and the bus bit positions used to select command words.
package icw_ocw_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_UNINIT,
        ST_WAIT2,
        ST_WAIT3,
        ST_WAIT4,
        ST_READY
    } state_t;

    // A0 level selecting ICW1/OCW2/OCW3 versus ICW2-4/OCW1
    localparam logic A0_CMD  = 1'b0;
    localparam logic A0_DATA = 1'b1;

    localparam int unsigned D4_BIT = 4;  // ICW1 marker when A0=0
    localparam int unsigned D3_BIT = 3;  // OCW3 (1) versus OCW2 (0)
    localparam int unsigned D1_BIT = 1;  // SNGL in ICW1
    localparam int unsigned D0_BIT = 0;  // IC4 in ICW1

endpackage

// File: rtl/strobe_edge_detect.sv
// Registers wrN/csN and flags the cycle in which a chip-selected write
// strobe has just risen.
module strobe_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic csN,
    input  logic wrN,
    output logic accept
);

    logic wr_q;
    logic cs_q;

    // History resets to "not writing" so a strobe in flight at reset is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= 1'b1;
            cs_q <= 1'b1;
        end else begin
            wr_q <= wrN;
            cs_q <= csN;
        end
    end

    assign accept = !wr_q && !cs_q && wrN;

endmodule

// File: rtl/icw_ocw_sequencer.sv
// Decodes CPU writes into ICW1-4 initialization and OCW1-3 operation command
// strobes, tracking the initialization sequence with a small state machine.
module icw_ocw_sequencer
    import icw_ocw_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       csN,
    input  logic       wrN,
    input  logic       rdN,
    input  logic       A0,
    input  logic [7:0] DIn,
    output logic [7:0] DBus,
    output logic       ICW1flag,
    output logic       ICW2flag,
    output logic       ICW3flag,
    output logic       ICW4flag,
    output logic       OCW1flag,
    output logic       OCW2flag,
    output logic       OCW3flag,
    output logic       rden,
    output logic       A0out,
    output logic       initDone
);

    state_t     state;
    logic       sngl;
    logic       ic4;
    logic       wr_accept;
    logic [7:0] din_q;
    logic       a0_q;

    strobe_edge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .csN    (csN),
        .wrN    (wrN),
        .accept (wr_accept)
    );

    // Bus value and address from the last low cycle of the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= '0;
            a0_q  <= 1'b0;
        end else if (!wrN) begin
            din_q <= DIn;
            a0_q  <= A0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_UNINIT;
            sngl     <= 1'b0;
            ic4      <= 1'b0;
            DBus     <= '0;
            ICW1flag <= 1'b0;
            ICW2flag <= 1'b0;
            ICW3flag <= 1'b0;
            ICW4flag <= 1'b0;
            OCW1flag <= 1'b0;
            OCW2flag <= 1'b0;
            OCW3flag <= 1'b0;
            rden     <= 1'b0;
            A0out    <= 1'b0;
        end else begin
            ICW1flag <= 1'b0;
            ICW2flag <= 1'b0;
            ICW3flag <= 1'b0;
            ICW4flag <= 1'b0;
            OCW1flag <= 1'b0;
            OCW2flag <= 1'b0;
            OCW3flag <= 1'b0;
            rden     <= !csN && !rdN && wrN;
            A0out    <= A0;

            if (wr_accept) begin
                if (a0_q == A0_CMD && din_q[D4_BIT]) begin
                    ICW1flag <= 1'b1;
                    DBus     <= din_q;
                    sngl     <= din_q[D1_BIT];
                    ic4      <= din_q[D0_BIT];
                    state    <= ST_WAIT2;
                end else begin
                    case (state)
                        ST_WAIT2: if (a0_q == A0_DATA) begin
                            ICW2flag <= 1'b1;
                            DBus     <= din_q;
                            if (!sngl)
                                state <= ST_WAIT3;
                            else if (ic4)
                                state <= ST_WAIT4;
                            else
                                state <= ST_READY;
                        end
                        ST_WAIT3: if (a0_q == A0_DATA) begin
                            ICW3flag <= 1'b1;
                            DBus     <= din_q;
                            state    <= ic4 ? ST_WAIT4 : ST_READY;
                        end
                        ST_WAIT4: if (a0_q == A0_DATA) begin
                            ICW4flag <= 1'b1;
                            DBus     <= din_q;
                            state    <= ST_READY;
                        end
                        ST_READY: begin
                            DBus <= din_q;
                            if (a0_q == A0_DATA)
                                OCW1flag <= 1'b1;
                            else if (!din_q[D3_BIT])
                                OCW2flag <= 1'b1;
                            else
                                OCW3flag <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign initDone = (state == ST_READY);

endmodule

// File: tb/tb_icw_ocw_sequencer.sv
// Self-checking bench for icw_ocw_sequencer: table of writes with expected
// strobes scored through a queue, plus hand sequences for reset/read/cs cases.
module tb_icw_ocw_sequencer;

    logic       clk;
    logic       rst_n;
    logic       csN;
    logic       wrN;
    logic       rdN;
    logic       A0;
    logic [7:0] DIn;
    logic [7:0] DBus;
    logic       ICW1flag, ICW2flag, ICW3flag, ICW4flag;
    logic       OCW1flag, OCW2flag, OCW3flag;
    logic       rden;
    logic       A0out;
    logic       initDone;

    icw_ocw_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .csN      (csN),
        .wrN      (wrN),
        .rdN      (rdN),
        .A0       (A0),
        .DIn      (DIn),
        .DBus     (DBus),
        .ICW1flag (ICW1flag),
        .ICW2flag (ICW2flag),
        .ICW3flag (ICW3flag),
        .ICW4flag (ICW4flag),
        .OCW1flag (OCW1flag),
        .OCW2flag (OCW2flag),
        .OCW3flag (OCW3flag),
        .rden     (rden),
        .A0out    (A0out),
        .initDone (initDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_ICW1 = 7'b1000000;
    localparam logic [6:0] F_ICW2 = 7'b0100000;
    localparam logic [6:0] F_ICW3 = 7'b0010000;
    localparam logic [6:0] F_ICW4 = 7'b0001000;
    localparam logic [6:0] F_OCW1 = 7'b0000100;
    localparam logic [6:0] F_OCW2 = 7'b0000010;
    localparam logic [6:0] F_OCW3 = 7'b0000001;

    typedef struct {
        logic        a0;
        logic [7:0]  data;
        int unsigned len;
        logic [6:0]  flags;
        logic [7:0]  dbus;
        logic        init;
    } vec_t;

    typedef struct {
        int         due;
        logic [6:0] flags;
        logic [7:0] dbus;
        logic       init;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   errors;
    logic [6:0] flags_now;

    assign flags_now = {ICW1flag, ICW2flag, ICW3flag, ICW4flag,
                        OCW1flag, OCW2flag, OCW3flag};

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expectations fall due on the cycle their strobe is registered
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("flags", {1'b0, flags_now}, {1'b0, e.flags});
            check("dbus", DBus, e.dbus);
            check("initDone", {7'b0, initDone}, {7'b0, e.init});
        end else if (rst_n) begin
            check("idle_flags", {1'b0, flags_now}, 8'h00);
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic a0, input logic [7:0] d, input int unsigned len,
                            input logic [6:0] ef, input logic [7:0] ed, input logic ei);
        csN = 1'b0;
        wrN = 1'b0;
        A0  = a0;
        DIn = d;
        tick(len);
        // bus changes as the strobe rises; the captured value must not follow it
        wrN = 1'b1;
        csN = 1'b1;
        A0  = ~a0;
        DIn = 8'($urandom);
        sb.push_back('{due: cyc + 1, flags: ef, dbus: ed, init: ei});
        tick(2);
    endtask

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        csN    = 1'b1;
        wrN    = 1'b1;
        rdN    = 1'b1;
        A0     = 1'b0;
        DIn    = 8'h00;

        vecs[0]  = '{1'b0, 8'h0B, 1, F_NONE, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 8'h55, 1, F_NONE, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 8'h1D, 1, F_ICW1, 8'h1D, 1'b0};
        vecs[3]  = '{1'b1, 8'hCA, 3, F_ICW2, 8'hCA, 1'b0};
        vecs[4]  = '{1'b0, 8'h04, 1, F_NONE, 8'hCA, 1'b0};
        vecs[5]  = '{1'b1, 8'h1E, 1, F_ICW3, 8'h1E, 1'b0};
        vecs[6]  = '{1'b1, 8'h12, 2, F_ICW4, 8'h12, 1'b1};
        vecs[7]  = '{1'b1, 8'h6A, 1, F_OCW1, 8'h6A, 1'b1};
        vecs[8]  = '{1'b0, 8'hC4, 1, F_OCW2, 8'hC4, 1'b1};
        vecs[9]  = '{1'b0, 8'h0B, 1, F_OCW3, 8'h0B, 1'b1};
        vecs[10] = '{1'b0, 8'h13, 2, F_ICW1, 8'h13, 1'b0};
        vecs[11] = '{1'b1, 8'h40, 1, F_ICW2, 8'h40, 1'b0};
        vecs[12] = '{1'b1, 8'h8F, 1, F_ICW4, 8'h8F, 1'b1};

        @(negedge clk);
        check("rst_flags", {1'b0, flags_now}, 8'h00);
        check("rst_dbus", DBus, 8'h00);
        check("rst_misc", {5'b0, rden, A0out, initDone}, 8'h00);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        for (int i = 0; i < 13; i++)
            do_write(vecs[i].a0, vecs[i].data, vecs[i].len,
                     vecs[i].flags, vecs[i].dbus, vecs[i].init);

        // Registered read enable and A0
        rdN = 1'b0; csN = 1'b0; A0 = 1'b1;
        tick(1);
        check("rden_on", {7'b0, rden}, 8'h01);
        check("a0out_hi", {7'b0, A0out}, 8'h01);
        A0 = 1'b0;
        tick(1);
        check("a0out_lo", {7'b0, A0out}, 8'h00);
        rdN = 1'b1; csN = 1'b1;
        tick(1);
        check("rden_off", {7'b0, rden}, 8'h00);

        // Write and read together: write wins
        csN = 1'b0; wrN = 1'b0; rdN = 1'b0; A0 = 1'b1; DIn = 8'h77;
        tick(1);
        check("rden_wr_prio", {7'b0, rden}, 8'h00);
        wrN = 1'b1; csN = 1'b1; rdN = 1'b1;
        sb.push_back('{due: cyc + 1, flags: F_OCW1, dbus: 8'h77, init: 1'b1});
        tick(2);

        // Chip select released before the strobe rises: dropped
        csN = 1'b0; wrN = 1'b0; A0 = 1'b1; DIn = 8'h33;
        tick(1);
        csN = 1'b1;
        tick(1);
        wrN = 1'b1;
        sb.push_back('{due: cyc + 1, flags: F_NONE, dbus: 8'h77, init: 1'b1});
        tick(2);

        // Reset in WAIT3 with an ICW1-looking write in flight
        do_write(1'b0, 8'h1D, 1, F_ICW1, 8'h1D, 1'b0);
        do_write(1'b1, 8'hCA, 1, F_ICW2, 8'hCA, 1'b0);
        csN = 1'b0; wrN = 1'b0; A0 = 1'b0; DIn = 8'h1D;
        tick(1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dbus", DBus, 8'h00);
        check("mid_rst_misc", {1'b0, flags_now}, 8'h00);
        tick(2);
        check("mid_rst_state", {5'b0, rden, A0out, initDone}, 8'h00);
        rst_n = 1'b1;
        wrN = 1'b1;
        csN = 1'b1;
        sb.push_back('{due: cyc + 1, flags: F_NONE, dbus: 8'h00, init: 1'b0});
        tick(2);

        // First non-ICW1 write after reset is ignored
        do_write(1'b1, 8'h5A, 1, F_NONE, 8'h00, 1'b0);
        tick(3);

        check("sb_drained", 8'(sb.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
